// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared constants, action encoding and helpers for the IF stage
package if_id_stage_pkg;

  // Default reset PC; fetch restarts here after every reset.
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  // Bubble written into IF/ID on reset/flush (sll $0,$0,0).
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  // What the stage does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    ACT_RESET    = 2'd0,
    ACT_REDIRECT = 2'd1,
    ACT_STALL    = 2'd2,
    ACT_ADVANCE  = 2'd3
  } stage_action_e;

  // Priority: reset > redirect > stall > advance.
  // A redirect beats a stall because the stalled instruction is on the wrong path.
  function automatic stage_action_e decode_action(input logic rst,
                                                  input logic redirect,
                                                  input logic pc_ifwrite);
    if (rst)              return ACT_RESET;
    else if (redirect)    return ACT_REDIRECT;
    else if (!pc_ifwrite) return ACT_STALL;
    else                  return ACT_ADVANCE;
  endfunction

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// rtl/if_id_stage_if.sv - instruction memory bus and IF/ID register outputs
interface if_id_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        id_valid;

  // The fetch stage drives the address and the IF/ID register contents.
  modport master (
    output imem_addr,
    input  imem_rdata,
    output id_instr,
    output id_pc_plus4,
    output id_valid
  );

  // Memory model / decode side.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  id_instr,
    input  id_pc_plus4,
    input  id_valid
  );
endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - PC register with redirect mux, target alignment and +4 adder
module pc_reg
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        target_misaligned
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Sequential +4 wraps naturally modulo 2^32; no error is raised for it.
  assign pc_plus4          = pc_q + 32'd4;
  assign pc                = pc_q;
  assign target_misaligned = (redirect_pc[1:0] != 2'b00);

  // Next-PC select: redirect target (word aligned) beats sequential, otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect)     pc_d = align_word(redirect_pc);
    else if (advance) pc_d = pc_plus4;
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= align_word(RESET_PC);
    else     pc_q <= pc_d;
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch stage and IF/ID pipeline register
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  if_id_stage_if.master      bus,
  input  logic               PC_IFWrite,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               misalign_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  stage_action_e action;
  logic [31:0]   pc;
  logic [31:0]   pc_plus4;
  logic          target_misaligned;

  logic [31:0]      id_instr_q,    id_instr_d;
  logic [31:0]      id_pc_plus4_q, id_pc_plus4_d;
  logic             id_valid_q,    id_valid_d;
  logic             misalign_q,    misalign_d;
  logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,   flush_cnt_d;

  // One decision per cycle drives both the PC and the IF/ID register.
  assign action = decode_action(rst, redirect, PC_IFWrite);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk               (clk),
    .rst               (rst),
    .advance           (action == ACT_ADVANCE),
    .redirect          (action == ACT_REDIRECT),
    .redirect_pc       (redirect_pc),
    .pc                (pc),
    .pc_plus4          (pc_plus4),
    .target_misaligned (target_misaligned)
  );

  // Memory always sees the live PC, so a stalled fetch simply re-reads the same word.
  assign bus.imem_addr   = pc;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.id_valid    = id_valid_q;
  assign misalign_err    = misalign_q;
  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;

  // Next state of IF/ID, sticky flag and saturating counters.
  always_comb begin
    id_instr_d    = id_instr_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_valid_d    = id_valid_q;
    misalign_d    = misalign_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    case (action)
      ACT_REDIRECT: begin
        id_instr_d    = NOP_INSTR;
        id_pc_plus4_d = 32'd0;
        id_valid_d    = 1'b0;
        misalign_d    = misalign_q | target_misaligned;
        if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      ACT_STALL: begin
        if (!(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      ACT_ADVANCE: begin
        id_instr_d    = bus.imem_rdata;
        id_pc_plus4_d = pc_plus4;
        id_valid_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // IF/ID register and bookkeeping state; reset wins over any redirect or stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_instr_q    <= NOP_INSTR;
      id_pc_plus4_q <= 32'd0;
      id_valid_q    <= 1'b0;
      misalign_q    <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      id_instr_q    <= id_instr_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_valid_q    <= id_valid_d;
      misalign_q    <= misalign_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed table-driven bench for if_id_stage
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_ifwrite;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err, misalign_err4;
  logic [31:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int tests_run = 0;
  int tests_failed = 0;

  if_id_stage_if bus ();
  if_id_stage_if bus4 ();

  always #5 clk = ~clk;

  // ROM contents: word[k] = k + 0x100.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return {2'b00, addr[31:2]} + 32'h100;
  endfunction

  assign bus.imem_rdata  = rom_word(bus.imem_addr);
  assign bus4.imem_rdata = rom_word(bus4.imem_addr);

  if_id_stage #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .PC_IFWrite   (pc_ifwrite),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  if_id_stage #(.CNT_W(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus4),
    .PC_IFWrite   (pc_ifwrite),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err4),
    .stall_cnt    (stall_cnt4),
    .flush_cnt    (flush_cnt4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        pc_ifwrite;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic        exp_mis;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // wr redir target       addr          instr          pc4           v  mis stall flush
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        32'h4,        32'h100,       32'h4,        1'b1, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,        32'h8,        32'h101,       32'h8,        1'b1, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,        32'h8,        32'h101,       32'h8,        1'b1, 1'b0, 1, 0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,        32'h8,        32'h101,       32'h8,        1'b1, 1'b0, 2, 0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'hC,        32'h102,       32'hC,        1'b1, 1'b0, 2, 0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'h10,       32'h103,       32'h10,       1'b1, 1'b0, 2, 0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,        32'h14,       32'h104,       32'h14,       1'b1, 1'b0, 2, 0};
    vecs[7]  = '{1'b0, 1'b1, 32'h40,       32'h40,       32'h0,         32'h0,        1'b0, 1'b0, 2, 1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        32'h44,       32'h110,       32'h44,       1'b1, 1'b0, 2, 1};
    vecs[9]  = '{1'b1, 1'b1, 32'h46,       32'h44,       32'h0,         32'h0,        1'b0, 1'b1, 2, 2};
    vecs[10] = '{1'b1, 1'b0, 32'h0,        32'h48,       32'h111,       32'h48,       1'b1, 1'b1, 2, 2};
    vecs[11] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,       32'h0,        1'b0, 1'b1, 2, 3};
    vecs[12] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'h4000_00FF, 32'h0,        1'b1, 1'b1, 2, 3};

    rst = 1'b1;
    pc_ifwrite = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    check("reset_addr",  bus.imem_addr,   32'h0);
    check("reset_instr", bus.id_instr,    32'h0);
    check("reset_pc4",   bus.id_pc_plus4, 32'h0);
    check("reset_valid", {31'd0, bus.id_valid}, 32'h0);
    check("reset_mis",   {31'd0, misalign_err}, 32'h0);
    check("reset_stall", stall_cnt, 32'h0);
    check("reset_flush", flush_cnt, 32'h0);

    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      pc_ifwrite  = vecs[i].pc_ifwrite;
      redirect    = vecs[i].redirect;
      redirect_pc = vecs[i].redirect_pc;
      step();
      check($sformatf("v%0d_addr", i),  bus.imem_addr,   vecs[i].exp_addr);
      check($sformatf("v%0d_instr", i), bus.id_instr,    vecs[i].exp_instr);
      check($sformatf("v%0d_pc4", i),   bus.id_pc_plus4, vecs[i].exp_pc4);
      check($sformatf("v%0d_valid", i), {31'd0, bus.id_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_mis", i),   {31'd0, misalign_err}, {31'd0, vecs[i].exp_mis});
      check($sformatf("v%0d_stall", i), stall_cnt, vecs[i].exp_stall);
      check($sformatf("v%0d_flush", i), flush_cnt, vecs[i].exp_flush);
    end

    // Long stall: 32-bit counter keeps counting, 4-bit counter saturates.
    pc_ifwrite = 1'b0;
    redirect = 1'b0;
    repeat (20) step();
    check("long_stall_cnt",   stall_cnt, 32'd22);
    check("sat_stall_cnt4",   {28'd0, stall_cnt4}, 32'hF);
    check("sat_flush_cnt4",   {28'd0, flush_cnt4}, 32'd3);
    check("long_stall_addr",  bus.imem_addr, 32'h0);
    check("long_stall_instr", bus.id_instr,  32'h4000_00FF);
    check("long_stall_valid", {31'd0, bus.id_valid}, 32'h1);
    check("mis_sticky",       {31'd0, misalign_err}, 32'h1);
    check("mis_sticky4",      {31'd0, misalign_err4}, 32'h1);

    // Reset during a stalled misaligned redirect: reset values win.
    rst = 1'b1;
    pc_ifwrite = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h46;
    step();
    check("rst_mid_addr",   bus.imem_addr, 32'h0);
    check("rst_mid_valid",  {31'd0, bus.id_valid}, 32'h0);
    check("rst_mid_instr",  bus.id_instr, 32'h0);
    check("rst_mid_mis",    {31'd0, misalign_err}, 32'h0);
    check("rst_mid_stall",  stall_cnt, 32'h0);
    check("rst_mid_flush",  flush_cnt, 32'h0);
    check("rst_mid_stall4", {28'd0, stall_cnt4}, 32'h0);

    rst = 1'b0;
    redirect = 1'b0;
    pc_ifwrite = 1'b1;
    step();
    check("restart_addr",  bus.imem_addr,   32'h4);
    check("restart_instr", bus.id_instr,    32'h100);
    check("restart_pc4",   bus.id_pc_plus4, 32'h4);
    check("restart_valid", {31'd0, bus.id_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
